culsans_ar_id_remap: RTL and testbench

//   Parametrised read-path ID remapper between the widened crossbar-side ID

---
 rtl/culsans_ar_id_remap.sv | 178 +++++++++++++++++
 tb/tb_culsans_ar_id_remap.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/culsans_ar_id_remap.sv
// culsans_ar_id_remap
//   Read-path ID remapper. Wide upstream AR IDs are bound to a small table of
//   slots; the slot index is the downstream AR ID. R beats come back on the
//   slot index and are mapped back to the original upstream ID.
//   One slot per distinct in-flight ID keeps same-ID ordering intact. The
//   block stalls the AR channel when the matching slot's counter is full, or
//   when an ID misses and no slot is free.
// Ports
//   clk_i, rst_i            clock, async active-high reset
//   slv_ar_* / mst_ar_*     upstream / downstream AR handshake and ID
//   mst_r_* / slv_r_*       downstream / upstream R handshake, ID and last
//   full_o, busy_o          all slots / any slot in use (registered)

// One table slot: owner ID plus count of outstanding ARs.
module culsans_ar_id_remap_slot #(
  parameter int SlvIdWidth = 8,
  parameter int CntW       = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  commit_i,
  input  logic                  retire_i,
  input  logic [SlvIdWidth-1:0] id_i,
  output logic                  valid_o,
  output logic [SlvIdWidth-1:0] id_o,
  output logic [CntW-1:0]       cnt_o
);
  logic                  valid_d, valid_q;
  logic [SlvIdWidth-1:0] id_d, id_q;
  logic [CntW-1:0]       cnt_d, cnt_q;

  // commit and retire in the same cycle cancel out
  always_comb begin
    cnt_d = cnt_q;
    id_d  = id_q;
    if (commit_i) id_d = id_i;
    case ({commit_i, retire_i})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_o = valid_q;
  assign id_o    = id_q;
  assign cnt_o   = cnt_q;
endmodule

module culsans_ar_id_remap #(
  parameter int SlvIdWidth   = 8,
  parameter int MstIdWidth   = 2,
  parameter int NumSlots     = 4,
  parameter int MaxTxnsPerId = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  slv_ar_valid_i,
  output logic                  slv_ar_ready_o,
  input  logic [SlvIdWidth-1:0] slv_ar_id_i,
  output logic                  mst_ar_valid_o,
  input  logic                  mst_ar_ready_i,
  output logic [MstIdWidth-1:0] mst_ar_id_o,
  input  logic                  mst_r_valid_i,
  output logic                  mst_r_ready_o,
  input  logic [MstIdWidth-1:0] mst_r_id_i,
  input  logic                  mst_r_last_i,
  output logic                  slv_r_valid_o,
  input  logic                  slv_r_ready_i,
  output logic [SlvIdWidth-1:0] slv_r_id_o,
  output logic                  full_o,
  output logic                  busy_o
);
  localparam int CntW  = $clog2(MaxTxnsPerId + 1);
  localparam int SlotW = (NumSlots > 1) ? $clog2(NumSlots) : 1;

  if (NumSlots > (1 << MstIdWidth)) begin : g_bad_cfg
    $error("NumSlots does not fit in MstIdWidth");
  end

  logic [NumSlots-1:0]                 slot_valid;
  logic [NumSlots-1:0][SlvIdWidth-1:0] slot_id;
  logic [NumSlots-1:0][CntW-1:0]       slot_cnt;
  logic [NumSlots-1:0]                 commit, retire, r_sel;

  logic             hit_any, free_any, grant, ar_hs, r_last_hs, r_slot_ok;
  logic [SlotW-1:0] hit_idx, free_idx, sel_idx;

  // AR lookup. Walk downward so the lowest index wins; a hit is unique
  // because an ID never owns more than one slot.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int k = NumSlots - 1; k >= 0; k--) begin
      if (slot_valid[k] && slot_id[k] == slv_ar_id_i) begin
        hit_any = 1'b1;
        hit_idx = SlotW'(k);
      end
      if (!slot_valid[k]) begin
        free_any = 1'b1;
        free_idx = SlotW'(k);
      end
    end
    sel_idx = hit_any ? hit_idx : free_idx;
    // a full hit slot stalls; it must never spill into a second slot
    grant   = hit_any ? (slot_cnt[hit_idx] < CntW'(MaxTxnsPerId)) : free_any;
  end

  assign mst_ar_valid_o = slv_ar_valid_i & grant;
  assign slv_ar_ready_o = mst_ar_ready_i & grant;
  assign mst_ar_id_o    = MstIdWidth'(sel_idx);
  assign ar_hs          = mst_ar_valid_o & mst_ar_ready_i;

  // R path: decode the slot without indexing past NumSlots
  always_comb begin
    r_sel      = '0;
    r_slot_ok  = 1'b0;
    slv_r_id_o = '0;
    for (int k = 0; k < NumSlots; k++) begin
      if (mst_r_id_i == MstIdWidth'(k)) begin
        r_sel[k]   = 1'b1;
        r_slot_ok  = slot_valid[k] && (slot_cnt[k] != '0);
        slv_r_id_o = slot_id[k];
      end
    end
  end

  assign slv_r_valid_o = mst_r_valid_i;
  assign mst_r_ready_o = slv_r_ready_i;
  assign r_last_hs     = mst_r_valid_i & slv_r_ready_i & mst_r_last_i;

  // Retire to an idle slot is a protocol error: suppressed so counters never wrap.
  always_comb begin
    for (int k = 0; k < NumSlots; k++) begin
      commit[k] = ar_hs && (sel_idx == SlotW'(k));
      retire[k] = r_last_hs && r_sel[k] && r_slot_ok;
    end
  end

  for (genvar g = 0; g < NumSlots; g++) begin : g_slot
    culsans_ar_id_remap_slot #(
      .SlvIdWidth (SlvIdWidth),
      .CntW       (CntW)
    ) u_slot (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .commit_i (commit[g]),
      .retire_i (retire[g]),
      .id_i     (slv_ar_id_i),
      .valid_o  (slot_valid[g]),
      .id_o     (slot_id[g]),
      .cnt_o    (slot_cnt[g])
    );
  end

  assign full_o = &slot_valid;
  assign busy_o = |slot_valid;

`ifndef SYNTHESIS
  r_retire_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    r_last_hs |-> r_slot_ok)
    else $error("R last on a slot with nothing outstanding");
`endif
endmodule

// File: tb/tb_culsans_ar_id_remap.sv
module tb_culsans_ar_id_remap;
  logic       clk = 1'b0;
  logic       rst;
  logic       slv_ar_valid, slv_ar_ready, mst_ar_valid, mst_ar_ready;
  logic [7:0] slv_ar_id;
  logic [1:0] mst_ar_id;
  logic       mst_r_valid, mst_r_ready, mst_r_last, slv_r_valid, slv_r_ready;
  logic [1:0] mst_r_id;
  logic [7:0] slv_r_id;
  logic       full, busy;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] ar_q[$];
  logic [31:0] r_q[$];

  always #5 clk = ~clk;

  culsans_ar_id_remap #(
    .SlvIdWidth(8), .MstIdWidth(2), .NumSlots(4), .MaxTxnsPerId(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_ar_valid_i(slv_ar_valid), .slv_ar_ready_o(slv_ar_ready), .slv_ar_id_i(slv_ar_id),
    .mst_ar_valid_o(mst_ar_valid), .mst_ar_ready_i(mst_ar_ready), .mst_ar_id_o(mst_ar_id),
    .mst_r_valid_i(mst_r_valid), .mst_r_ready_o(mst_r_ready), .mst_r_id_i(mst_r_id),
    .mst_r_last_i(mst_r_last),
    .slv_r_valid_o(slv_r_valid), .slv_r_ready_i(slv_r_ready), .slv_r_id_o(slv_r_id),
    .full_o(full), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // scoreboard: pop an expectation on every observed handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (mst_ar_valid && mst_ar_ready) begin
        if (ar_q.size() == 0) chk("ar_unexp", 32'(mst_ar_id), 32'hFFFF_FFFF);
        else chk("ar_id", 32'(mst_ar_id), ar_q.pop_front());
      end
      if (slv_r_valid && slv_r_ready) begin
        if (r_q.size() == 0) chk("r_unexp", 32'(slv_r_id), 32'hFFFF_FFFF);
        else chk("r_id", 32'(slv_r_id), r_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_go(input logic [7:0] id, input logic [1:0] exp);
    slv_ar_valid = 1'b1; slv_ar_id = id;
    ar_q.push_back(32'(exp));
    step();
    slv_ar_valid = 1'b0;
  endtask

  task automatic r_go(input logic [1:0] rid, input logic last, input logic [7:0] exp);
    mst_r_valid = 1'b1; mst_r_id = rid; mst_r_last = last;
    r_q.push_back(32'(exp));
    step();
    mst_r_valid = 1'b0; mst_r_last = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    slv_ar_valid = 1'b0; slv_ar_id = '0; mst_ar_ready = 1'b1;
    mst_r_valid = 1'b0; mst_r_id = '0; mst_r_last = 1'b0; slv_r_ready = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ar_id", 32'(mst_ar_id), 0);
    chk("rst_ar_v", 32'(mst_ar_valid), 0);
    step();
    rst = 1'b0;
    step();

    // 1: first AR lands in slot 0
    ar_go(8'h2A, 2'd0);
    chk("t1_busy", 32'(busy), 1);
    r_go(2'd0, 1'b1, 8'h2A);
    chk("t1_idle", 32'(busy), 0);

    // 2: per-ID limit stalls the fifth AR until one retires
    for (int i = 0; i < 4; i++) ar_go(8'h05, 2'd0);
    chk("t2_full", 32'(full), 0);
    slv_ar_valid = 1'b1; slv_ar_id = 8'h05;
    @(negedge clk);
    chk("t2_stall_v", 32'(mst_ar_valid), 0);
    chk("t2_stall_rdy", 32'(slv_ar_ready), 0);
    step();
    mst_r_valid = 1'b1; mst_r_id = 2'd0; mst_r_last = 1'b1;
    r_q.push_back(32'h05);
    @(negedge clk);
    chk("t2_stall_r", 32'(mst_ar_valid), 0);
    step();
    mst_r_valid = 1'b0; mst_r_last = 1'b0;
    ar_q.push_back(0);
    @(negedge clk);
    chk("t2_go", 32'(mst_ar_valid), 1);
    step();
    slv_ar_valid = 1'b0;
    for (int i = 0; i < 4; i++) r_go(2'd0, 1'b1, 8'h05);
    chk("t2_idle", 32'(busy), 0);

    // 3: four distinct IDs fill the table; a fifth waits for a free slot
    ar_go(8'h11, 2'd0);
    ar_go(8'h12, 2'd1);
    ar_go(8'h13, 2'd2);
    ar_go(8'h14, 2'd3);
    chk("t3_full", 32'(full), 1);
    slv_ar_valid = 1'b1; slv_ar_id = 8'h15;
    @(negedge clk);
    chk("t3_stall", 32'(mst_ar_valid), 0);
    step();
    // 4: non-last beats keep the slot; ID restored on every beat
    mst_r_valid = 1'b1; mst_r_id = 2'd1; mst_r_last = 1'b0;
    r_q.push_back(32'h12);
    step();
    r_q.push_back(32'h12);
    step();
    mst_r_valid = 1'b0;
    chk("t4_full_hold", 32'(full), 1);
    // retire slot 2; the stalled AR must still wait this cycle
    mst_r_valid = 1'b1; mst_r_id = 2'd2; mst_r_last = 1'b1;
    r_q.push_back(32'h13);
    @(negedge clk);
    chk("t3_stall_r", 32'(mst_ar_valid), 0);
    step();
    mst_r_valid = 1'b0; mst_r_last = 1'b0;
    ar_q.push_back(2);
    step();
    slv_ar_valid = 1'b0;
    chk("t3_refull", 32'(full), 1);
    r_go(2'd1, 1'b1, 8'h12);
    chk("t4_freed", 32'(full), 0);
    r_go(2'd0, 1'b1, 8'h11);
    r_go(2'd2, 1'b1, 8'h15);
    r_go(2'd3, 1'b1, 8'h14);
    chk("t3_idle", 32'(busy), 0);

    // 5: commit and retire together on slot 0 keep cnt=1, valid=1
    ar_go(8'h33, 2'd0);
    slv_ar_valid = 1'b1; slv_ar_id = 8'h33;
    mst_r_valid = 1'b1; mst_r_id = 2'd0; mst_r_last = 1'b1;
    ar_q.push_back(0); r_q.push_back(32'h33);
    step();
    // retire slot 0 while a new ID misses: must allocate slot 1
    slv_ar_id = 8'h44;
    ar_q.push_back(1); r_q.push_back(32'h33);
    step();
    slv_ar_valid = 1'b0; mst_r_valid = 1'b0; mst_r_last = 1'b0;
    chk("t5_busy", 32'(busy), 1);
    r_go(2'd1, 1'b1, 8'h44);
    chk("t5_idle", 32'(busy), 0);

    // 6: async reset with three slots busy
    ar_go(8'h61, 2'd0);
    ar_go(8'h62, 2'd1);
    ar_go(8'h63, 2'd2);
    chk("t6_busy", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_full", 32'(full), 0);
    step();
    rst = 1'b0;
    step();
    ar_go(8'h70, 2'd0);

    step();
    chk("ar_q_drained", 32'(ar_q.size()), 0);
    chk("r_q_drained", 32'(r_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
